// File: rtl/mem_arb_pkg.sv
// Shared types for the FE/MEM single-port RAM arbiter: FSM encoding, requester IDs,
// default bus widths and a saturating increment used by the optional stall counters.
package mem_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the FE, MEM and RAM handshakes around the arbiter.
// slave = arbiter view, master = pipeline stages plus RAM.
interface mem_port_arbiter_if #(
    parameter int AW = mem_arb_pkg::AW_DEF,
    parameter int DW = mem_arb_pkg::DW_DEF
) ();

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          flush;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          mem_stall;

    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ack;

    modport slave (
        input  if_req, if_addr, flush,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  ram_rdata, ram_ack,
        output if_rdata, if_valid, if_stall,
        output mem_rdata, mem_valid, mem_stall,
        output ram_req, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, flush,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output ram_rdata, ram_ack,
        input  if_rdata, if_valid, if_stall,
        input  mem_rdata, mem_valid, mem_stall,
        input  ram_req, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_arb_stats.sv
// Saturating per-stage stall-cycle counters; only instantiated when the arbiter
// is built with MEM_ARB_STATS_EN.
module mem_arb_stats
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        mem_stall,
    output logic [15:0] if_wait_cycles,
    output logic [15:0] mem_wait_cycles
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_wait_cycles  <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (if_stall)  if_wait_cycles  <= sat_inc16(if_wait_cycles);
            if (mem_stall) mem_wait_cycles <= sat_inc16(mem_wait_cycles);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises FE fetches and MEM loads/stores onto one single-ported RAM, with
// MEM priority bounded by an IF starvation limit. MEM_ARB_STATS_EN adds stall counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]        if_wait_cycles,
    output logic [15:0]        mem_wait_cycles
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state;
    logic [3:0]    starve_cnt;
    logic          discard;

    logic          arb_en;
    logic          if_cand;
    logic          mem_cand;
    logic          gnt_if;
    logic          gnt_mem;
    req_id_t       winner;
    logic          gnt_we;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;
    logic [3:0]    starve_nxt;
    logic          drop_fetch;

    // Arbitration happens every edge in IDLE and on the ack edge otherwise; the
    // requester being completed is masked so it cannot be re-granted on its own ack.
    always_comb begin
        arb_en     = (state == IDLE) | bus.ram_ack;
        if_cand    = bus.if_req & ~bus.flush & (state != BUSY_IF);
        mem_cand   = bus.mem_req & (state != BUSY_MEM);
        gnt_if     = arb_en & if_cand & (~mem_cand | (starve_cnt == LIMIT));
        gnt_mem    = arb_en & mem_cand & ~gnt_if;
        winner     = gnt_if ? REQ_IF : REQ_MEM;
        gnt_we     = gnt_mem & bus.mem_we;
        gnt_addr   = gnt_if ? bus.if_addr : bus.mem_addr;
        gnt_wdata  = gnt_if ? bus.ram_wdata : bus.mem_wdata;
        drop_fetch = discard | bus.flush;

        starve_nxt = starve_cnt;
        if (!bus.if_req || gnt_if)
            starve_nxt = '0;
        else if (gnt_mem && starve_cnt != LIMIT)
            starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            discard       <= 1'b0;
            bus.ram_req   <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.if_valid  <= 1'b0;
            bus.mem_rdata <= '0;
            bus.mem_valid <= 1'b0;
        end else begin
            bus.if_valid  <= 1'b0;
            bus.mem_valid <= 1'b0;
            starve_cnt    <= starve_nxt;

            if (state == BUSY_IF && bus.flush)
                discard <= 1'b1;

            if (state == BUSY_IF && bus.ram_ack) begin
                discard <= 1'b0;
                if (!drop_fetch) begin
                    bus.if_valid <= 1'b1;
                    bus.if_rdata <= bus.ram_rdata;
                end
            end

            if (state == BUSY_MEM && bus.ram_ack) begin
                bus.mem_valid <= 1'b1;
                if (!bus.ram_we)
                    bus.mem_rdata <= bus.ram_rdata;
            end

            if (gnt_if || gnt_mem) begin
                state         <= (winner == REQ_IF) ? BUSY_IF : BUSY_MEM;
                bus.ram_req   <= 1'b1;
                bus.ram_we    <= gnt_we;
                bus.ram_addr  <= gnt_addr;
                bus.ram_wdata <= gnt_wdata;
            end else if (arb_en) begin
                state       <= IDLE;
                bus.ram_req <= 1'b0;
            end
        end
    end

    assign bus.if_stall  = bus.if_req  & ~bus.if_valid;
    assign bus.mem_stall = bus.mem_req & ~bus.mem_valid;

`ifdef MEM_ARB_STATS_EN
    mem_arb_stats u_stats (
        .clk             (CLOCK_50),
        .rst             (reset),
        .if_stall        (bus.if_stall),
        .mem_stall       (bus.mem_stall),
        .if_wait_cycles  (if_wait_cycles),
        .mem_wait_cycles (mem_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable RAM model plus
// hand-computed expectations for fetch, collision, store, starvation, flush and reset.
module tb_mem_port_arbiter;

    logic CLOCK_50;
    logic reset;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [15:0] if_wait_cycles;
    logic [15:0] mem_wait_cycles;
`endif

    mem_port_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(4)) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .bus             (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .if_wait_cycles  (if_wait_cycles),
        .mem_wait_cycles (mem_wait_cycles)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // RAM model controls, written only by the main process
    int          ram_lat   = 1;
    logic        ram_auto  = 1'b1;
    logic        use_fixed = 1'b0;
    logic [15:0] fixed_val = 16'h0;
    int          late_req  = 0;
    logic [15:0] served[$];

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // RAM: acks ram_lat cycles after seeing ram_req; data is ~addr unless fixed
    initial begin
        int cnt;
        int late_done;
        cnt = 0;
        late_done = 0;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = 16'h0;
        forever begin
            @(negedge CLOCK_50);
            #2;
            if (bus.ram_ack) begin
                bus.ram_ack = 1'b0;
                cnt = 0;
            end else if (late_req != late_done) begin
                bus.ram_ack = 1'b1;
                late_done++;
            end else if (ram_auto && bus.ram_req && !reset) begin
                cnt++;
                if (cnt >= ram_lat) begin
                    bus.ram_ack   = 1'b1;
                    bus.ram_rdata = use_fixed ? fixed_val : ~bus.ram_addr;
                    served.push_back(bus.ram_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    // which: 0 = if_valid, 1 = mem_valid
    task automatic wait_valid(input string tag, input int which, input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            ok = (which == 0) ? bus.if_valid : bus.mem_valid;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int q0;
        logic ok;
        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 16'h0;
        bus.flush     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 16'h0;
        bus.mem_wdata = 16'h0;
        repeat (3) @(negedge CLOCK_50);

        chk("rst_state",     32'(dut.state),     32'd0);
        chk("rst_ram_req",   32'(bus.ram_req),   32'd0);
        chk("rst_ram_addr",  32'(bus.ram_addr),  32'h0);
        chk("rst_if_valid",  32'(bus.if_valid),  32'd0);
        chk("rst_mem_rdata", 32'(bus.mem_rdata), 32'h0);
        reset = 1'b0;
        tick();

        // lone fetch, RAM latency 2
        ram_lat = 2; use_fixed = 1'b1; fixed_val = 16'hA5A5;
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        #1 chk("lf_stall_pre", 32'(bus.if_stall), 32'd1);
        tick();
        chk("lf_ram_req",  32'(bus.ram_req),  32'd1);
        chk("lf_ram_addr", 32'(bus.ram_addr), 32'h0010);
        chk("lf_ram_we",   32'(bus.ram_we),   32'd0);
        tick();
        chk("lf_no_valid", 32'(bus.if_valid), 32'd0);
        chk("lf_stall",    32'(bus.if_stall), 32'd1);
        tick();
        chk("lf_valid",    32'(bus.if_valid), 32'd1);
        chk("lf_rdata",    32'(bus.if_rdata), 32'h0000A5A5);
        chk("lf_stall_off", 32'(bus.if_stall), 32'd0);
        chk("lf_idle",     32'(dut.state),    32'd0);
        bus.if_req = 1'b0;
        tick();
        chk("lf_pulse", 32'(bus.if_valid), 32'd0);

        // collision: MEM load first, IF granted on the MEM ack edge
        ram_lat = 1; use_fixed = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 16'h0020;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 16'h0200;
        tick();
        chk("col_mem_first", 32'(dut.state),    32'd2);
        chk("col_mem_addr",  32'(bus.ram_addr), 32'h0200);
        chk("col_starve1",   32'(dut.starve_cnt), 32'd1);
        tick();
        chk("col_mem_valid", 32'(bus.mem_valid), 32'd1);
        chk("col_mem_rdata", 32'(bus.mem_rdata), 32'h0000FDFF);
        chk("col_if_gnt",    32'(dut.state),     32'd1);
        chk("col_req_held",  32'(bus.ram_req),   32'd1);
        chk("col_if_addr",   32'(bus.ram_addr),  32'h0020);
        chk("col_starve0",   32'(dut.starve_cnt), 32'd0);
        bus.mem_req = 1'b0;
        wait_valid("col_if_wait", 0, 10);
        chk("col_if_rdata", 32'(bus.if_rdata), 32'h0000FFDF);
        bus.if_req = 1'b0;
        tick();

        // store, RAM latency 3
        ram_lat = 3;
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 16'h0300; bus.mem_wdata = 16'h1234;
        tick();
        chk("st_we",    32'(bus.ram_we),    32'd1);
        chk("st_addr",  32'(bus.ram_addr),  32'h0300);
        chk("st_wdata", 32'(bus.ram_wdata), 32'h1234);
        tick();
        tick();
        chk("st_hold_addr",  32'(bus.ram_addr),  32'h0300);
        chk("st_hold_wdata", 32'(bus.ram_wdata), 32'h1234);
        chk("st_no_valid",   32'(bus.mem_valid), 32'd0);
        chk("st_stall",      32'(bus.mem_stall), 32'd1);
        tick();
        chk("st_valid", 32'(bus.mem_valid), 32'd1);
        chk("st_rdata", 32'(bus.mem_rdata), 32'h0000FDFF);
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        tick();

        // starvation: flush hides IF while MEM is re-granted four times
        ram_lat = 1;
        q0 = served.size();
        bus.if_req = 1'b1; bus.if_addr = 16'h0020; bus.flush = 1'b1;
        bus.mem_req = 1'b1; bus.mem_addr = 16'h0400;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = (served.size() - q0) >= 4;
        end
        chk("sv_four_mem", 32'(ok), 32'd1);
        chk("sv_starve_sat", 32'(dut.starve_cnt), 32'd4);
        chk("sv_idle", 32'(dut.state), 32'd0);
        bus.flush = 1'b0;
        tick();
        chk("sv_if_forced", 32'(dut.state),      32'd1);
        chk("sv_if_addr",   32'(bus.ram_addr),   32'h0020);
        chk("sv_starve_clr", 32'(dut.starve_cnt), 32'd0);
        for (int k = 0; k < 4; k++)
            if (served.size() > q0 + k)
                chk("sv_mem_order", 32'(served[q0 + k]), 32'h0400);
        wait_valid("sv_if_wait", 0, 10);
        chk("sv_mem_after_if", 32'(dut.state), 32'd2);
        bus.if_req = 1'b0;
        wait_valid("sv_mem_wait", 1, 10);
        bus.mem_req = 1'b0;
        tick();

        // flush during a fetch discards its data
        ram_lat = 3; use_fixed = 1'b1; fixed_val = 16'hBEEF;
        bus.if_req = 1'b1; bus.if_addr = 16'h0030;
        tick();
        chk("fl_busy_if", 32'(dut.state), 32'd1);
        bus.flush = 1'b1;
        tick();
        chk("fl_discard", 32'(dut.discard), 32'd1);
        bus.flush = 1'b0; bus.if_req = 1'b0;
        tick();
        chk("fl_wait", 32'(bus.if_valid), 32'd0);
        tick();
        chk("fl_no_valid", 32'(bus.if_valid), 32'd0);
        chk("fl_rdata",    32'(bus.if_rdata), 32'h0000FFDF);
        chk("fl_idle",     32'(dut.state),    32'd0);
        chk("fl_disc_clr", 32'(dut.discard),  32'd0);
        chk("fl_ram_req",  32'(bus.ram_req),  32'd0);
        tick();
        chk("fl_still_no", 32'(bus.if_valid), 32'd0);
        ram_lat = 1; use_fixed = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 16'h0040;
        wait_valid("fl_refetch", 0, 10);
        chk("fl_refetch_data", 32'(bus.if_rdata), 32'h0000FFBF);
        bus.if_req = 1'b0;
        tick();

        // reset while a load is outstanding, then a stray ack
        ram_auto = 1'b0;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 16'h0500;
        tick();
        chk("rs_busy_mem", 32'(dut.state),   32'd2);
        chk("rs_ram_req",  32'(bus.ram_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rs_req_drop",  32'(bus.ram_req),   32'd0);
        chk("rs_state",     32'(dut.state),     32'd0);
        chk("rs_addr",      32'(bus.ram_addr),  32'h0);
        chk("rs_mem_rdata", 32'(bus.mem_rdata), 32'h0);
        chk("rs_if_rdata",  32'(bus.if_rdata),  32'h0);
        bus.mem_req = 1'b0;
        tick();
        reset = 1'b0;
        late_req++;
        tick();
        chk("rs_late_valid", 32'(bus.mem_valid), 32'd0);
        chk("rs_late_state", 32'(dut.state),     32'd0);
        tick();
        chk("rs_late_valid2", 32'(bus.mem_valid), 32'd0);
        chk("rs_late_req",    32'(bus.ram_req),   32'd0);
        chk("rs_late_if",     32'(bus.if_valid),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data RAM between the FE stage (instruction read) and the MEM stage (load/store).
- Sits between the pipeline stages and the RAM.
- Serialises accesses and returns read data with a valid pulse.
- Generates per-stage stall so FE and MEM freeze until served.
- Honours the EX branch flush by discarding in-flight fetches.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- STARVE_LIMIT, 4, consecutive MEM grants tolerated while IF waits before IF is forced; legal range 1..15.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  FE read request; level, held until if_valid.
- if_addr  in  AW  fetch address; stable while if_req.
- if_rdata  out  DW  fetched instruction.
- if_valid  out  1  one-cycle pulse, if_rdata good.
- if_stall  out  1  FE must hold.
- flush  in  1  branch taken in EX; abort fetch.
- mem_req  in  1  MEM access request; level, held until mem_valid.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  AW  data address.
- mem_wdata  in  DW  store data.
- mem_rdata  out  DW  load data.
- mem_valid  out  1  one-cycle pulse, access complete.
- mem_stall  out  1  MEM must hold.
- ram_req  out  1  RAM request; level until ram_ack.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid with ram_ack.
- ram_ack  in  1  RAM completion, sampled on rising CLOCK_50.

Behaviour:
- Clock and reset: one clock, CLOCK_50. reset is asynchronous and active-high.
- Reset values: state=IDLE; ram_req, ram_we, if_valid, mem_valid = 0; ram_addr, ram_wdata, if_rdata, mem_rdata = 0; starve_cnt=0; discard=0.
- States:
  - IDLE: no RAM access in flight.
  - BUSY_IF: fetch in flight.
  - BUSY_MEM: data access in flight.
- Arbitration (at each edge in IDLE, and at the ack edge in BUSY_x):
  - The requester just served is masked at its ack edge.
  - mem_req wins over if_req, except when if_req=1 and starve_cnt==STARVE_LIMIT; IF wins then.
  - if_req is ignored in any cycle where flush=1.
- Grant edge:
  - ram_addr, ram_we, ram_wdata are registered from the winner (ram_we=0 for IF).
  - ram_req goes 1 and the state moves to BUSY_x.
  - RAM outputs stay stable until ram_ack.
- Ack edge in BUSY_x:
  - ram_rdata is registered into x_rdata; x_valid pulses for exactly one cycle (stores also pulse mem_valid; mem_rdata is then unchanged).
  - Re-arbitrate: grant another requester, else go to IDLE with ram_req=0.
- Latency: request seen in IDLE at edge N gives ram_req high after N; ack sampled at edge N+k (k>=1); x_valid high after edge N+k.
- Stall: x_stall = x_req & ~x_valid, combinational.
- Flush:
  - In BUSY_IF, flush sets discard. At the ack edge the RAM transaction completes, if_valid stays 0, if_rdata is unchanged, and discard clears.
  - Flush in BUSY_MEM or IDLE sets nothing.
- starve_cnt:
  - +1, saturating at STARVE_LIMIT, on each MEM grant while if_req=1.
  - Cleared on IF grant or whenever if_req=0.
- Boundaries:
  - ram_ack in IDLE is ignored.
  - Simultaneous mem_req and if_req follow the priority above.
  - Reset mid-transaction returns to IDLE and drops ram_req; a late ram_ack is ignored.
  - A request dropped before service is a protocol error; no recovery is required.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs if_wait_cycles[15:0] and mem_wait_cycles[15:0].
  - Each is a saturating count of cycles with x_stall=1; both reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_MEM=2'd2);
  - requester IDs (REQ_IF, REQ_MEM);
  - AW/DW defaults.
- One sub-module, mem_arb_stats: two saturating 16-bit stall counters, instantiated only under MEM_ARB_STATS_EN.

Test Plan:
- Lone fetch: if_req=1, if_addr=16'h0010, RAM acks after 2 cycles with 16'hA5A5 -> ram_addr=16'h0010, ram_we=0; if_valid pulses once with if_rdata=16'hA5A5; if_stall high until then.
- Collision: if_req and mem_req (load 16'h0200) rise the same cycle -> MEM granted first; on its ack, IF is granted at that same edge with no IDLE cycle between.
- Store: mem_req=1, mem_we=1, mem_addr=16'h0300, mem_wdata=16'h1234 -> ram_we=1 with address and data held until ack; mem_valid pulses; mem_rdata unchanged.
- Starvation: mem_req held continuously, if_req=1, STARVE_LIMIT=4 -> exactly 4 MEM grants, then an IF grant; starve_cnt returns to 0.
- Flush: flush=1 during BUSY_IF, ack later with 16'hBEEF -> if_valid stays 0, if_rdata unchanged, state returns to IDLE; a new fetch is then served normally.
- Reset in BUSY_MEM before ack -> ram_req drops immediately; a subsequent ram_ack produces no mem_valid; all outputs are at their reset values.
